mcpu_ctrl_alu: RTL and testbench



---
 rtl/mcpu_ctrl_alu.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mcpu_ctrl_alu.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_ctrl_alu.sv
// mcpu_ctrl_alu: multicycle control FSM and 32-bit ALU slice for the MIPS-subset CPU.
// Control outputs are a Moore decode of the state register; the ALU path is combinational.
module mcpu_ctrl_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir_data,
    input  logic [31:0] a_data,
    input  logic [31:0] b_data,
    input  logic [31:0] pc,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic        write_pc,
    output logic        iord,
    output logic        write_mem,
    output logic        write_dr,
    output logic        write_ir,
    output logic        write_c,
    output logic        write_a,
    output logic        write_b,
    output logic        write_reg,
    output logic        memtoreg,
    output logic        regdst,
    output logic [1:0]  pcsource,
    output logic [1:0]  alu_ctrl,
    output logic        alu_srcA,
    output logic [1:0]  alu_srcB,
    output logic [3:0]  state_out,
    output logic [3:0]  insn_type,
    output logic [3:0]  insn_code,
    output logic [2:0]  insn_stage
);

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_EX_R     = 4'd2,
        S_EX_I     = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_R     = 4'd7,
        S_WB_I     = 4'd8,
        S_WB_LW    = 4'd9,
        S_BR       = 4'd10,
        S_JMP      = 4'd11
    } state_t;

    localparam logic [3:0] T_R     = 4'h0;
    localparam logic [3:0] T_IARI  = 4'h1;
    localparam logic [3:0] T_LW    = 4'h2;
    localparam logic [3:0] T_SW    = 4'h3;
    localparam logic [3:0] T_BEQ   = 4'h4;
    localparam logic [3:0] T_BNE   = 4'h5;
    localparam logic [3:0] T_J     = 4'h6;
    localparam logic [3:0] T_UNK   = 4'hF;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_OR   = 2'b11;

    state_t      state_r;
    state_t      state_nxt_s;
    state_t      dec_state_s;
    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [31:0] opa_s;
    logic [31:0] opb_s;
    logic        wpc_s, iord_s, wmem_s, wdr_s, wir_s, wc_s, wa_s, wb_s, wreg_s;
    logic        br_s;
    logic        br_take_s;
    logic        unused_ir_bits_s;

    assign op_s    = ir_data[31:26];
    assign funct_s = ir_data[5:0];

    // The jump target is assembled in the PC unit, so these IR bits are not consumed here.
    assign unused_ir_bits_s = ^ir_data[25:16];

    // Instruction class and ALU operation decode from opcode/funct.
    always_comb begin
        insn_type = T_UNK;
        insn_code = 4'd0;
        case (op_s)
            6'h00: begin
                case (funct_s)
                    6'h20:   begin insn_type = T_R;   insn_code = 4'd0; end
                    6'h22:   begin insn_type = T_R;   insn_code = 4'd1; end
                    6'h24:   begin insn_type = T_R;   insn_code = 4'd2; end
                    6'h25:   begin insn_type = T_R;   insn_code = 4'd3; end
                    default: begin insn_type = T_UNK; insn_code = 4'd0; end
                endcase
            end
            6'h08:   begin insn_type = T_IARI; insn_code = 4'd0; end
            6'h0C:   begin insn_type = T_IARI; insn_code = 4'd2; end
            6'h0D:   begin insn_type = T_IARI; insn_code = 4'd3; end
            6'h23:   begin insn_type = T_LW;   insn_code = 4'd0; end
            6'h2B:   begin insn_type = T_SW;   insn_code = 4'd0; end
            6'h04:   begin insn_type = T_BEQ;  insn_code = 4'd1; end
            6'h05:   begin insn_type = T_BNE;  insn_code = 4'd1; end
            6'h02:   begin insn_type = T_J;    insn_code = 4'd0; end
            default: begin insn_type = T_UNK;  insn_code = 4'd0; end
        endcase
    end

    // State register with synchronous reset back to fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IF;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state sequencing; unreachable codes fall back to fetch.
    always_comb begin
        state_nxt_s = S_IF;
        case (state_r)
            S_IF: state_nxt_s = S_ID;
            S_ID: begin
                case (insn_type)
                    T_R:          state_nxt_s = S_EX_R;
                    T_IARI:       state_nxt_s = S_EX_I;
                    T_LW, T_SW:   state_nxt_s = S_MEM_ADDR;
                    T_BEQ, T_BNE: state_nxt_s = S_BR;
                    T_J:          state_nxt_s = S_JMP;
                    default:      state_nxt_s = S_IF;
                endcase
            end
            S_EX_R: state_nxt_s = S_WB_R;
            S_EX_I: state_nxt_s = S_WB_I;
            S_MEM_ADDR: begin
                if (insn_type == T_LW) begin
                    state_nxt_s = S_MEM_RD;
                end else if (insn_type == T_SW) begin
                    state_nxt_s = S_MEM_WR;
                end else begin
                    state_nxt_s = S_IF;
                end
            end
            S_MEM_RD: state_nxt_s = S_WB_LW;
            default:  state_nxt_s = S_IF;
        endcase
    end

    // While in reset the selects follow the fetch decode; strobes are masked below.
    assign dec_state_s = rst ? S_IF : state_r;

    // Moore decode of strobes and mux selects.
    always_comb begin
        wpc_s    = 1'b0;
        iord_s   = 1'b0;
        wmem_s   = 1'b0;
        wdr_s    = 1'b0;
        wir_s    = 1'b0;
        wc_s     = 1'b0;
        wa_s     = 1'b0;
        wb_s     = 1'b0;
        wreg_s   = 1'b0;
        br_s     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        pcsource = 2'b00;
        alu_ctrl = OP_ADD;
        alu_srcA = 1'b0;
        alu_srcB = 2'b00;
        case (dec_state_s)
            S_IF: begin
                wir_s    = 1'b1;
                wpc_s    = 1'b1;
                alu_srcB = 2'b01;
            end
            S_ID: begin
                wa_s     = 1'b1;
                wb_s     = 1'b1;
                wc_s     = 1'b1;
                alu_srcB = 2'b10;
            end
            S_EX_R: begin
                alu_srcA = 1'b1;
                alu_ctrl = insn_code[1:0];
                wc_s     = 1'b1;
            end
            S_EX_I: begin
                alu_srcA = 1'b1;
                alu_srcB = (op_s == 6'h08) ? 2'b10 : 2'b11;
                alu_ctrl = insn_code[1:0];
                wc_s     = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_srcA = 1'b1;
                alu_srcB = 2'b10;
                wc_s     = 1'b1;
            end
            S_MEM_RD: begin
                iord_s = 1'b1;
                wdr_s  = 1'b1;
            end
            S_MEM_WR: begin
                iord_s = 1'b1;
                wmem_s = 1'b1;
            end
            S_WB_R: begin
                regdst = 1'b1;
                wreg_s = 1'b1;
            end
            S_WB_I: wreg_s = 1'b1;
            S_WB_LW: begin
                memtoreg = 1'b1;
                wreg_s   = 1'b1;
            end
            // C keeps the branch target computed in ID; the ALU only compares A and B.
            S_BR: begin
                alu_srcA = 1'b1;
                alu_ctrl = OP_SUB;
                pcsource = 2'b01;
                br_s     = 1'b1;
            end
            S_JMP: begin
                wpc_s    = 1'b1;
                pcsource = 2'b10;
            end
            default: begin
                wpc_s = 1'b0;
            end
        endcase
    end

    // ALU operand muxes and operation.
    always_comb begin
        opa_s = alu_srcA ? a_data : pc;
        case (alu_srcB)
            2'b00:   opb_s = b_data;
            2'b01:   opb_s = 32'd1;
            2'b10:   opb_s = {{16{ir_data[15]}}, ir_data[15:0]};
            2'b11:   opb_s = {16'd0, ir_data[15:0]};
            default: opb_s = b_data;
        endcase
        case (alu_ctrl)
            OP_ADD:  alu_out = opa_s + opb_s;
            OP_SUB:  alu_out = opa_s - opb_s;
            OP_AND:  alu_out = opa_s & opb_s;
            OP_OR:   alu_out = opa_s | opb_s;
            default: alu_out = 32'd0;
        endcase
    end

    assign zero      = (alu_out == 32'd0);
    assign br_take_s = ((insn_type == T_BEQ) & zero) | ((insn_type == T_BNE) & ~zero);

    assign write_pc  = ~rst & (wpc_s | (br_s & br_take_s));
    assign iord      = ~rst & iord_s;
    assign write_mem = ~rst & wmem_s;
    assign write_dr  = ~rst & wdr_s;
    assign write_ir  = ~rst & wir_s;
    assign write_c   = ~rst & wc_s;
    assign write_a   = ~rst & wa_s;
    assign write_b   = ~rst & wb_s;
    assign write_reg = ~rst & wreg_s;
    assign state_out = state_r;

    // Phase tag of the current state.
    always_comb begin
        case (state_r)
            S_IF:                      insn_stage = 3'd0;
            S_ID:                      insn_stage = 3'd1;
            S_EX_R, S_EX_I, S_MEM_ADDR,
            S_BR, S_JMP:               insn_stage = 3'd2;
            S_MEM_RD, S_MEM_WR:        insn_stage = 3'd3;
            S_WB_R, S_WB_I, S_WB_LW:   insn_stage = 3'd4;
            default:                   insn_stage = 3'd0;
        endcase
    end

endmodule

// File: tb/tb_mcpu_ctrl_alu.sv
// tb_mcpu_ctrl_alu: table vectors, reset corner sequence and random instructions
// checked cycle by cycle against an instruction-level reference model.
module tb_mcpu_ctrl_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir_data, a_data, b_data, pc;
    logic [31:0] alu_out;
    logic        zero, write_pc, iord, write_mem, write_dr, write_ir, write_c;
    logic        write_a, write_b, write_reg, memtoreg, regdst, alu_srcA;
    logic [1:0]  pcsource, alu_ctrl, alu_srcB;
    logic [3:0]  state_out, insn_type, insn_code;
    logic [2:0]  insn_stage;

    int checks = 0;
    int failures = 0;
    logic [31:0] alu_log [0:15];
    int last_cycles;

    typedef int iq_t[$];
    typedef struct {
        logic [31:0] ir, a, b, p;
        int          typ, code, cycles, exec_cyc;
        logic [31:0] exec_alu;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mcpu_ctrl_alu dut (
        .clk(clk), .rst(rst), .ir_data(ir_data), .a_data(a_data), .b_data(b_data), .pc(pc),
        .alu_out(alu_out), .zero(zero), .write_pc(write_pc), .iord(iord),
        .write_mem(write_mem), .write_dr(write_dr), .write_ir(write_ir), .write_c(write_c),
        .write_a(write_a), .write_b(write_b), .write_reg(write_reg), .memtoreg(memtoreg),
        .regdst(regdst), .pcsource(pcsource), .alu_ctrl(alu_ctrl), .alu_srcA(alu_srcA),
        .alu_srcB(alu_srcB), .state_out(state_out), .insn_type(insn_type),
        .insn_code(insn_code), .insn_stage(insn_stage)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] ctl_now();
        return {write_pc, iord, write_mem, write_dr, write_ir, write_c,
                write_a, write_b, write_reg, memtoreg, regdst};
    endfunction

    // ---------------- reference model ----------------
    function automatic int cls(input logic [31:0] ir);
        logic [5:0] op;
        logic [5:0] fn;
        op = ir[31:26];
        fn = ir[5:0];
        if (op == 6'h00) return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25) ? 0 : 15;
        if (op == 6'h08 || op == 6'h0C || op == 6'h0D) return 1;
        if (op == 6'h23) return 2;
        if (op == 6'h2B) return 3;
        if (op == 6'h04) return 4;
        if (op == 6'h05) return 5;
        if (op == 6'h02) return 6;
        return 15;
    endfunction

    function automatic int model_code(input logic [31:0] ir);
        int c;
        c = cls(ir);
        if (c == 0) return (ir[5:0] == 6'h20) ? 0 : (ir[5:0] == 6'h22) ? 1 : (ir[5:0] == 6'h24) ? 2 : 3;
        if (c == 1) return (ir[31:26] == 6'h08) ? 0 : (ir[31:26] == 6'h0C) ? 2 : 3;
        if (c == 4 || c == 5) return 1;
        return 0;
    endfunction

    function automatic iq_t path_of(input int c);
        iq_t p;
        p = {};
        p.push_back(0);
        p.push_back(1);
        case (c)
            0: begin p.push_back(2); p.push_back(7); end
            1: begin p.push_back(3); p.push_back(8); end
            2: begin p.push_back(4); p.push_back(5); p.push_back(9); end
            3: begin p.push_back(4); p.push_back(6); end
            4, 5: p.push_back(10);
            6: p.push_back(11);
            default: ;
        endcase
        return p;
    endfunction

    function automatic logic [31:0] model_alu(input int st, input logic [31:0] ir, a, b, p);
        logic [31:0] sx, zx;
        sx = {{16{ir[15]}}, ir[15:0]};
        zx = {16'd0, ir[15:0]};
        case (st)
            0: return p + 32'd1;
            1: return p + sx;
            2: begin
                if (ir[5:0] == 6'h20) return a + b;
                if (ir[5:0] == 6'h22) return a - b;
                if (ir[5:0] == 6'h24) return a & b;
                return a | b;
            end
            3: begin
                if (ir[31:26] == 6'h08) return a + sx;
                if (ir[31:26] == 6'h0C) return a & zx;
                return a | zx;
            end
            4: return a + sx;
            10: return a - b;
            default: return p + b;
        endcase
    endfunction

    // bit order: write_pc iord write_mem write_dr write_ir write_c write_a write_b write_reg memtoreg regdst
    function automatic logic [10:0] model_ctl(input int st, input bit taken);
        case (st)
            0: return 11'b10001000000;
            1: return 11'b00000111000;
            2, 3, 4: return 11'b00000100000;
            5: return 11'b01010000000;
            6: return 11'b01100000000;
            7: return 11'b00000000101;
            8: return 11'b00000000100;
            9: return 11'b00000000110;
            10: return taken ? 11'b10000000000 : 11'b00000000000;
            11: return 11'b10000000000;
            default: return 11'b00000000000;
        endcase
    endfunction

    function automatic int model_stage(input int st);
        if (st == 0) return 0;
        if (st == 1) return 1;
        if (st == 5 || st == 6) return 3;
        if (st >= 7 && st <= 9) return 4;
        return 2;
    endfunction

    // Caller is positioned inside an IF cycle (after its rising edge); returns in the next IF.
    task automatic run_insn(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] p);
        int   c, est;
        iq_t  path;
        bit   taken;
        logic [31:0] ea;
        ir_data = ir; a_data = a; b_data = b; pc = p;
        c = cls(ir);
        path = path_of(c);
        taken = (c == 4 && a == b) || (c == 5 && a != b);
        last_cycles = -1;
        #1;
        chk("insn_type", insn_type, c);
        chk("insn_code", insn_code, model_code(ir));
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                if (state_out == 4'd0) begin
                    last_cycles = k;
                    break;
                end
            end
            est = (k < path.size()) ? path[k] : 0;
            ea  = model_alu(est, ir, a, b, p);
            chk("state", state_out, est);
            chk("ctl", ctl_now(), model_ctl(est, taken));
            chk("alu_out", alu_out, ea);
            chk("zero", zero, (ea == 32'd0));
            chk("pcsource", pcsource, (est == 10) ? 1 : (est == 11) ? 2 : 0);
            chk("stage", insn_stage, model_stage(est));
            alu_log[k] = alu_out;
        end
        chk("cycles", last_cycles, path.size());
    endtask

    logic [31:0] rnd, ra, rb, rir;
    int sel;

    initial begin
        // ir, a, b, pc, type, code, cycles, cycle index of result, result
        vecs.push_back('{32'h00221820, 32'd5, 32'd7, 32'h100, 0, 0, 4, 2, 32'd12});
        vecs.push_back('{32'h00221822, 32'd5, 32'd7, 32'h100, 0, 1, 4, 2, 32'hFFFFFFFE});
        vecs.push_back('{32'h00221824, 32'h0000F0F0, 32'h0000FF00, 32'h100, 0, 2, 4, 2, 32'h0000F000});
        vecs.push_back('{32'h00221825, 32'h0000F0F0, 32'h0000FF00, 32'h100, 0, 3, 4, 2, 32'h0000FFF0});
        vecs.push_back('{32'h3422F0F0, 32'h0000000F, 32'd0, 32'h100, 1, 3, 4, 2, 32'h0000F0FF});
        vecs.push_back('{32'h30228000, 32'hFFFFFFFF, 32'd0, 32'h100, 1, 2, 4, 2, 32'h00008000});
        vecs.push_back('{32'h2022FFFF, 32'd0, 32'd0, 32'h100, 1, 0, 4, 2, 32'hFFFFFFFF});
        vecs.push_back('{32'h8C22FFFF, 32'h10, 32'd0, 32'h100, 2, 0, 5, 2, 32'h0000000F});
        vecs.push_back('{32'hAC22FFFF, 32'h10, 32'd0, 32'h100, 3, 0, 4, 2, 32'h0000000F});
        vecs.push_back('{32'h10220005, 32'd3, 32'd3, 32'h100, 4, 1, 3, 2, 32'd0});
        vecs.push_back('{32'h10220005, 32'd3, 32'd4, 32'h100, 4, 1, 3, 2, 32'hFFFFFFFF});
        vecs.push_back('{32'h14220005, 32'd3, 32'd3, 32'h100, 5, 1, 3, 2, 32'd0});
        vecs.push_back('{32'h08000010, 32'd0, 32'd0, 32'h100, 6, 0, 3, 2, 32'h100});
        vecs.push_back('{32'hFC000000, 32'd0, 32'd0, 32'h100, 15, 0, 2, 1, 32'h100});
        vecs.push_back('{32'h00221821, 32'd5, 32'd7, 32'h100, 15, 0, 2, 1, 32'h1921});

        rst = 1'b1; ir_data = 32'd0; a_data = 32'd0; b_data = 32'd0; pc = 32'h200;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state_out, 0);
        chk("rst_strobes", ctl_now(), 0);
        rst = 1'b0;

        // reset in the middle of lw (MEM_RD), then release
        ir_data = 32'h8C22FFFF; a_data = 32'h10;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("midlw_state", state_out, 5);
        chk("midlw_iord", iord, 1);
        rst = 1'b1;
        #1;
        chk("rst_mask_strobes", ctl_now(), 0);
        chk("rst_if_selects_alu", alu_out, 32'h201);
        @(posedge clk);
        #1;
        chk("rst_forced_state", state_out, 0);
        chk("rst_hold_strobes", ctl_now(), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_write_ir", write_ir, 1);
        chk("post_rst_write_pc", write_pc, 1);
        chk("post_rst_alu", alu_out, 32'h201);

        foreach (vecs[i]) begin
            run_insn(vecs[i].ir, vecs[i].a, vecs[i].b, vecs[i].p);
            chk("vec_type", insn_type, vecs[i].typ);
            chk("vec_code", insn_code, vecs[i].code);
            chk("vec_cycles", last_cycles, vecs[i].cycles);
            chk("vec_result", alu_log[vecs[i].exec_cyc], vecs[i].exec_alu);
        end

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 13);
            rnd = $urandom;
            ra  = $urandom;
            rb  = ($urandom_range(0, 1) == 0) ? ra : $urandom;
            case (sel)
                0:  rir = {6'h00, rnd[25:6], 6'h20};
                1:  rir = {6'h00, rnd[25:6], 6'h22};
                2:  rir = {6'h00, rnd[25:6], 6'h24};
                3:  rir = {6'h00, rnd[25:6], 6'h25};
                4:  rir = {6'h08, rnd[25:0]};
                5:  rir = {6'h0C, rnd[25:0]};
                6:  rir = {6'h0D, rnd[25:0]};
                7:  rir = {6'h23, rnd[25:0]};
                8:  rir = {6'h2B, rnd[25:0]};
                9:  rir = {6'h04, rnd[25:0]};
                10: rir = {6'h05, rnd[25:0]};
                11: rir = {6'h02, rnd[25:0]};
                12: rir = {6'h3F, rnd[25:0]};
                default: rir = {6'h00, rnd[25:6], 6'h21};
            endcase
            run_insn(rir, ra, rb, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
